// File: rtl/integration_window_capture.sv
// Per-channel windowed integrator: accumulates sum, sum-of-squares and valid-sample count
// per channel over a window of sample_valid strobes. At window close the totals are copied
// into a shadow bank and streamed as one fixed-length 64-bit AXI-stream packet, while the
// next window keeps integrating with no dead samples.
module integration_window_capture #(
  parameter int unsigned NUM_CH    = 16,
  parameter int unsigned WIDTH     = 18,
  parameter int unsigned ACC_WIDTH = 64,
  parameter int unsigned LEN_WIDTH = 32,
  parameter logic [7:0]  ID        = 8'hAB
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic [LEN_WIDTH-1:0]      window_len,
  input  logic [63:0]               in_timestamp,
  input  logic                      sample_valid,
  input  logic [NUM_CH*WIDTH-1:0]   sample_ch_data,
  input  logic [NUM_CH-1:0]         sample_ch_valid,
  output logic [63:0]               m_tdata,
  output logic                      m_tvalid,
  output logic                      m_tlast,
  input  logic                      m_tready,
  output logic [LEN_WIDTH-1:0]      dropped
);

  localparam int unsigned NWords = 4 + 3 * NUM_CH;
  localparam int unsigned IdxW   = $clog2(NWords);
  localparam int unsigned PW     = 2 * WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWords - 1);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // Stage 1: registered sample, qualifiers, square and the strobe itself
  logic                   s1_valid_q;
  logic [NUM_CH-1:0]      s1_chv_q;
  logic signed [WIDTH-1:0] s1_data_q [NUM_CH];
  logic signed [PW-1:0]   s1_prod_q [NUM_CH];
  logic [63:0]            s1_ts_q;

  // Live window accumulators
  logic                   ena_q;
  logic [LEN_WIDTH-1:0]   frames_q;
  logic [63:0]            win_ts_q;
  logic [ACC_WIDTH-1:0]   sum_q   [NUM_CH];
  logic [ACC_WIDTH-1:0]   sumsq_q [NUM_CH];
  logic [LEN_WIDTH-1:0]   cnt_q   [NUM_CH];
  logic [LEN_WIDTH-1:0]   pkt_cnt_q;
  logic [LEN_WIDTH-1:0]   dropped_q;

  // Shadow bank feeding the serializer
  logic [63:0]            sh_ts_q;
  logic [LEN_WIDTH-1:0]   sh_pkt_q;
  logic [LEN_WIDTH-1:0]   sh_frames_q;
  logic [ACC_WIDTH-1:0]   sh_sum_q   [NUM_CH];
  logic [ACC_WIDTH-1:0]   sh_sumsq_q [NUM_CH];
  logic [LEN_WIDTH-1:0]   sh_cnt_q   [NUM_CH];

  // Serializer
  state_e                 state_q;
  logic [IdxW-1:0]        idx_q;
  logic [IdxW-1:0]        idx_inc;
  logic [63:0]            m_tdata_q;
  logic                   m_tvalid_q;
  logic                   m_tlast_q;

  // Combinational window bookkeeping
  logic                   acc_en;
  logic                   close_len;
  logic                   flush;
  logic                   close;
  logic                   shadow_busy;
  logic                   load;
  logic                   drop;
  logic [LEN_WIDTH-1:0]   frames_inc;
  logic [LEN_WIDTH-1:0]   frames_add;
  logic [63:0]            ts_add;
  logic [ACC_WIDTH-1:0]   sum_add   [NUM_CH];
  logic [ACC_WIDTH-1:0]   sumsq_add [NUM_CH];
  logic [LEN_WIDTH-1:0]   cnt_add   [NUM_CH];
  logic signed [PW-1:0]   samp_ext  [NUM_CH];
  logic [63:0]            pkt_w     [NWords];

  // Sign-extend incoming samples so the square is formed at full 2*WIDTH precision
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      samp_ext[c] = PW'($signed(sample_ch_data[c*WIDTH +: WIDTH]));
    end
  end

  // Stage 1 register: data and its square are captured from the same strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_chv_q   <= '0;
      s1_ts_q    <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        s1_data_q[c] <= '0;
        s1_prod_q[c] <= '0;
      end
    end else begin
      s1_valid_q <= sample_valid;
      if (sample_valid) begin
        s1_chv_q <= sample_ch_valid;
        s1_ts_q  <= in_timestamp;
        for (int c = 0; c < NUM_CH; c++) begin
          s1_data_q[c] <= WIDTH'(samp_ext[c]);
          s1_prod_q[c] <= samp_ext[c] * samp_ext[c];
        end
      end
    end
  end

  // Accumulator + current contribution, close detection and shadow arbitration
  always_comb begin
    acc_en      = s1_valid_q && ena;
    frames_inc  = frames_q + LEN_WIDTH'(1);
    frames_add  = acc_en ? frames_inc : frames_q;
    ts_add      = (acc_en && (frames_q == '0)) ? s1_ts_q : win_ts_q;
    // >= so that lowering window_len below the running count closes on the next strobe
    close_len   = acc_en && (window_len != '0) && (frames_inc >= window_len);
    flush       = ena_q && !ena && (frames_q != '0);
    close       = close_len || flush;
    // The shadow is free again in the cycle its last word is accepted
    shadow_busy = (state_q == StSend) && !(m_tvalid_q && m_tready && m_tlast_q);
    load        = close && !shadow_busy;
    drop        = close && shadow_busy;
    for (int c = 0; c < NUM_CH; c++) begin
      if (acc_en && s1_chv_q[c]) begin
        sum_add[c]   = sum_q[c] + ACC_WIDTH'(s1_data_q[c]);
        sumsq_add[c] = sumsq_q[c] + ACC_WIDTH'(s1_prod_q[c]);
        cnt_add[c]   = cnt_q[c] + LEN_WIDTH'(1);
      end else begin
        sum_add[c]   = sum_q[c];
        sumsq_add[c] = sumsq_q[c];
        cnt_add[c]   = cnt_q[c];
      end
    end
  end

  // Stage 2: live accumulators, window counters, shadow load and drop accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      ena_q       <= 1'b0;
      frames_q    <= '0;
      win_ts_q    <= '0;
      pkt_cnt_q   <= '0;
      dropped_q   <= '0;
      sh_ts_q     <= '0;
      sh_pkt_q    <= '0;
      sh_frames_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        sum_q[c]      <= '0;
        sumsq_q[c]    <= '0;
        cnt_q[c]      <= '0;
        sh_sum_q[c]   <= '0;
        sh_sumsq_q[c] <= '0;
        sh_cnt_q[c]   <= '0;
      end
    end else begin
      ena_q <= ena;
      if (close) begin
        frames_q  <= '0;
        pkt_cnt_q <= pkt_cnt_q + LEN_WIDTH'(1);
        for (int c = 0; c < NUM_CH; c++) begin
          sum_q[c]   <= '0;
          sumsq_q[c] <= '0;
          cnt_q[c]   <= '0;
        end
      end else begin
        frames_q <= frames_add;
        win_ts_q <= ts_add;
        for (int c = 0; c < NUM_CH; c++) begin
          sum_q[c]   <= sum_add[c];
          sumsq_q[c] <= sumsq_add[c];
          cnt_q[c]   <= cnt_add[c];
        end
      end
      if (load) begin
        sh_ts_q     <= ts_add;
        sh_pkt_q    <= pkt_cnt_q;
        sh_frames_q <= frames_add;
        for (int c = 0; c < NUM_CH; c++) begin
          sh_sum_q[c]   <= sum_add[c];
          sh_sumsq_q[c] <= sumsq_add[c];
          sh_cnt_q[c]   <= cnt_add[c];
        end
      end
      if (drop) begin
        dropped_q <= dropped_q + LEN_WIDTH'(1);
      end
    end
  end

  // Packet word map; w0 uses the live drop count, captured when the packet starts
  always_comb begin
    pkt_w[0] = {ID, 8'h00, 16'(NWords), 32'(dropped_q)};
    pkt_w[1] = sh_ts_q;
    pkt_w[2] = 64'(sh_pkt_q);
    pkt_w[3] = 64'(sh_frames_q);
    for (int c = 0; c < NUM_CH; c++) begin
      pkt_w[4 + 3*c] = 64'(sh_cnt_q[c]);
      pkt_w[5 + 3*c] = 64'($signed(sh_sum_q[c]));
      pkt_w[6 + 3*c] = 64'($signed(sh_sumsq_q[c]));
    end
    idx_inc = idx_q + IdxW'(1);
  end

  // Serializer FSM with registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      m_tdata_q  <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            state_q    <= StSend;
            idx_q      <= '0;
            m_tdata_q  <= pkt_w[0];
            m_tvalid_q <= 1'b1;
            m_tlast_q  <= 1'b0;
          end
        end
        StSend: begin
          if (m_tvalid_q && m_tready) begin
            if (m_tlast_q) begin
              if (load) begin
                idx_q      <= '0;
                m_tdata_q  <= pkt_w[0];
                m_tvalid_q <= 1'b1;
                m_tlast_q  <= 1'b0;
              end else begin
                state_q    <= StIdle;
                idx_q      <= '0;
                m_tdata_q  <= '0;
                m_tvalid_q <= 1'b0;
                m_tlast_q  <= 1'b0;
              end
            end else begin
              idx_q     <= idx_inc;
              m_tdata_q <= pkt_w[idx_inc];
              m_tlast_q <= (idx_inc == LastIdx);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign dropped  = dropped_q;

endmodule

// File: tb/tb_integration_window_capture.sv
// Directed bench for integration_window_capture with two channels: table of windows plus
// hand-written flush, backpressure/drop, back-to-back and reset sequences.
module tb_integration_window_capture;

  localparam int unsigned NCH = 2;
  localparam int unsigned W   = 18;
  localparam logic [63:0] TS0 = 64'h0000_1000_0000_0000;

  logic              clk;
  logic              rst;
  logic              ena;
  logic [31:0]       window_len;
  logic [63:0]       in_timestamp;
  logic              sample_valid;
  logic [NCH*W-1:0]  sample_ch_data;
  logic [NCH-1:0]    sample_ch_valid;
  logic [63:0]       m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic              m_tready;
  logic [31:0]       dropped;

  integration_window_capture #(
    .NUM_CH   (NCH),
    .WIDTH    (W),
    .ACC_WIDTH(64),
    .LEN_WIDTH(32),
    .ID       (8'hAB)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ena            (ena),
    .window_len     (window_len),
    .in_timestamp   (in_timestamp),
    .sample_valid   (sample_valid),
    .sample_ch_data (sample_ch_data),
    .sample_ch_valid(sample_ch_valid),
    .m_tdata        (m_tdata),
    .m_tvalid       (m_tvalid),
    .m_tlast        (m_tlast),
    .m_tready       (m_tready),
    .dropped        (dropped)
  );

  typedef struct packed {
    int d0;
    int d1;
    bit v0;
    bit v1;
  } smp_t;

  typedef struct packed {
    int     n;
    longint c0;
    longint s0;
    longint q0;
    longint c1;
    longint s1;
    longint q1;
  } wexp_t;

  smp_t        smp  [13];
  wexp_t       wexp [4];
  logic [63:0] exp_w [10];
  logic [63:0] got   [$];
  bit          got_l [$];
  int          pkts;
  int          n_tests;
  int          n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Words are recorded on the falling edge; the handshake completes at the next rising edge
  always @(negedge clk) begin
    if (!rst && m_tvalid && m_tready) begin
      got.push_back(m_tdata);
      got_l.push_back(m_tlast);
      if (m_tlast) pkts++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input int d0, input int d1, input bit v0, input bit v1,
                      input logic [63:0] ts, input bit lat_chk);
    sample_ch_data  = {18'(d1), 18'(d0)};
    sample_ch_valid = {v1, v0};
    in_timestamp    = ts;
    sample_valid    = 1'b1;
    tick();
    sample_valid = 1'b0;
    if (lat_chk) check("lat_early", 64'(m_tvalid), 64'd0);
    tick();
    if (lat_chk) check("lat_tvalid", 64'(m_tvalid), 64'd1);
  endtask

  task automatic wait_pkts(input int target);
    int cyc;
    cyc = 0;
    while (pkts < target && cyc < 300) begin
      tick();
      cyc++;
    end
    check("pkt_arrival", 64'(pkts), 64'(target));
  endtask

  task automatic build_exp(input logic [31:0] drop, input logic [63:0] ts, input logic [63:0] idx,
                           input logic [63:0] frames, input logic [63:0] c0, input logic [63:0] s0,
                           input logic [63:0] q0, input logic [63:0] c1, input logic [63:0] s1,
                           input logic [63:0] q1);
    exp_w[0] = {8'hAB, 8'h00, 16'd10, drop};
    exp_w[1] = ts;
    exp_w[2] = idx;
    exp_w[3] = frames;
    exp_w[4] = c0;
    exp_w[5] = s0;
    exp_w[6] = q0;
    exp_w[7] = c1;
    exp_w[8] = s1;
    exp_w[9] = q1;
  endtask

  task automatic compare_pkt(input string tag, input int base);
    check({tag, "_len"}, 64'(got.size() >= base + 10), 64'd1);
    if (got.size() >= base + 10) begin
      for (int i = 0; i < 10; i++) begin
        check($sformatf("%s_w%0d", tag, i), got[base+i], exp_w[i]);
      end
      check({tag, "_tlast"}, {62'd0, got_l[base+8], got_l[base+9]}, 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d packets expected more", pkts);
    $fatal(1);
  end

  initial begin
    int          r;
    int          p;
    int          base;
    logic [63:0] hold_d;
    longint      s0;
    longint      q0;
    longint      s1;
    longint      q1;
    longint      tot;
    longint      a;
    longint      b;

    // Window table: {ch0, ch1, ch0 valid, ch1 valid}, then per-window expectations
    smp[0]  = '{3, 1, 1'b1, 1'b1};
    smp[1]  = '{-2, 2, 1'b1, 1'b1};
    smp[2]  = '{5, 3, 1'b1, 1'b1};
    smp[3]  = '{-1, 4, 1'b1, 1'b1};
    smp[4]  = '{3, 7, 1'b1, 1'b1};
    smp[5]  = '{-2, 100, 1'b1, 1'b0};
    smp[6]  = '{5, -7, 1'b1, 1'b1};
    smp[7]  = '{-1, 100, 1'b1, 1'b0};
    smp[8]  = '{-131072, 55, 1'b1, 1'b0};
    smp[9]  = '{131071, 55, 1'b1, 1'b0};
    smp[10] = '{0, 55, 1'b1, 1'b0};
    smp[11] = '{-5, 0, 1'b1, 1'b0};
    smp[12] = '{-5, 6, 1'b1, 1'b1};
    wexp[0] = '{4, 64'd4, 64'd5, 64'd39, 64'd4, 64'd10, 64'd30};
    wexp[1] = '{4, 64'd4, 64'd5, 64'd39, 64'd2, 64'd0, 64'd98};
    wexp[2] = '{3, 64'd3, -64'sd1, 64'd34359476225, 64'd0, 64'd0, 64'd0};
    wexp[3] = '{2, 64'd2, -64'sd10, 64'd50, 64'd1, 64'd6, 64'd36};

    n_tests = 0;
    n_fail = 0;
    pkts = 0;
    rst = 1'b1;
    ena = 1'b0;
    window_len = '0;
    in_timestamp = '0;
    sample_valid = 1'b0;
    sample_ch_data = '0;
    sample_ch_valid = '0;
    m_tready = 1'b1;
    repeat (3) tick();
    check("rst_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_tlast", 64'(m_tlast), 64'd0);
    check("rst_tdata", m_tdata, 64'd0);
    check("rst_dropped", 64'(dropped), 64'd0);
    rst = 1'b0;
    ena = 1'b1;
    tick();

    // Table-driven windows, pkt_counter 0..3
    r = 0;
    for (int v = 0; v < 4; v++) begin
      window_len = 32'(wexp[v].n);
      base = got.size();
      p = pkts;
      for (int k = 0; k < wexp[v].n; k++) begin
        send(smp[r].d0, smp[r].d1, smp[r].v0, smp[r].v1, TS0 + 64'(v * 256 + k),
             k == wexp[v].n - 1);
        r++;
      end
      wait_pkts(p + 1);
      build_exp(32'd0, TS0 + 64'(v * 256), 64'(v), 64'(wexp[v].n), wexp[v].c0, wexp[v].s0,
                wexp[v].q0, wexp[v].c1, wexp[v].s1, wexp[v].q1);
      compare_pkt($sformatf("vec%0d", v), base);
    end

    // Flush on ena falling with no automatic close
    window_len = '0;
    base = got.size();
    p = pkts;
    for (int k = 0; k < 3; k++) send(2, 9, 1'b1, 1'b0, 64'h2000 + 64'(k), 1'b0);
    ena = 1'b0;
    tick();
    check("flush_tvalid", 64'(m_tvalid), 64'd1);
    wait_pkts(p + 1);
    build_exp(32'd0, 64'h2000, 64'd4, 64'd3, 64'd3, 64'd6, 64'd12, 64'd0, 64'd0, 64'd0);
    compare_pkt("flush", base);
    ena = 1'b1;
    repeat (3) tick();
    ena = 1'b0;
    repeat (20) tick();
    check("flush_empty_pkts", 64'(pkts), 64'(p + 1));
    check("flush_empty_tvalid", 64'(m_tvalid), 64'd0);

    // Backpressure: first window held, the next four dropped
    ena = 1'b1;
    window_len = 32'd1;
    m_tready = 1'b0;
    base = got.size();
    p = pkts;
    for (int k = 0; k < 5; k++) begin
      send(10 * (k + 1), 0, 1'b1, 1'b0, 64'h3000 + 64'(k * 8), 1'b0);
      if (k == 0) hold_d = m_tdata;
      if (k == 2) check("drop_mid", 64'(dropped), 64'd2);
      repeat (6) tick();
    end
    check("stall_tvalid", 64'(m_tvalid), 64'd1);
    check("stall_tlast", 64'(m_tlast), 64'd0);
    check("stall_w0", m_tdata, 64'hAB00_000A_0000_0000);
    check("stall_stable", m_tdata, hold_d);
    check("drop_total", 64'(dropped), 64'd4);
    m_tready = 1'b1;
    wait_pkts(p + 1);
    build_exp(32'd0, 64'h3000, 64'd5, 64'd1, 64'd1, 64'd10, 64'd100, 64'd0, 64'd0, 64'd0);
    compare_pkt("held", base);
    base = got.size();
    send(60, 0, 1'b1, 1'b0, 64'h3100, 1'b0);
    wait_pkts(p + 2);
    build_exp(32'd4, 64'h3100, 64'd10, 64'd1, 64'd1, 64'd60, 64'd3600, 64'd0, 64'd0, 64'd0);
    compare_pkt("after_drop", base);

    // Back-to-back windows from a continuous strobe stream
    window_len = 32'd12;
    base = got.size();
    p = pkts;
    sample_ch_valid = 2'b11;
    for (int k = 0; k < 36; k++) begin
      sample_ch_data = {18'(3 * k - 50), 18'(k + 1)};
      in_timestamp = 64'h4000 + 64'(k);
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    wait_pkts(p + 3);
    tot = 0;
    for (int w = 0; w < 3; w++) begin
      s0 = 0;
      q0 = 0;
      s1 = 0;
      q1 = 0;
      for (int k = 12 * w; k < 12 * w + 12; k++) begin
        a = longint'(k + 1);
        b = longint'(3 * k - 50);
        s0 += a;
        q0 += a * a;
        s1 += b;
        q1 += b * b;
        tot += a;
      end
      build_exp(32'd4, 64'h4000 + 64'(12 * w), 64'(11 + w), 64'd12, 64'd12, s0, q0, 64'd12,
                s1, q1);
      compare_pkt($sformatf("b2b%0d", w), base + 10 * w);
    end
    if (got.size() >= base + 30) begin
      check("b2b_total", got[base+5] + got[base+15] + got[base+25], tot);
    end

    // Reset while the third word is on the bus
    window_len = 32'd1;
    send(9, 0, 1'b1, 1'b0, 64'h5000, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rstmid_tvalid", 64'(m_tvalid), 64'd0);
    check("rstmid_dropped", 64'(dropped), 64'd0);
    rst = 1'b0;
    tick();
    base = got.size();
    p = pkts;
    send(9, 0, 1'b1, 1'b0, 64'h5100, 1'b0);
    wait_pkts(p + 1);
    build_exp(32'd0, 64'h5100, 64'd0, 64'd1, 64'd1, 64'd9, 64'd81, 64'd0, 64'd0, 64'd0);
    compare_pkt("post_rst", base);

    // Lowering window_len below the running count closes on the next strobe
    window_len = 32'd5;
    base = got.size();
    p = pkts;
    for (int k = 0; k < 3; k++) send(1, 0, 1'b1, 1'b0, 64'h6000 + 64'(k), 1'b0);
    window_len = 32'd2;
    send(1, 0, 1'b1, 1'b0, 64'h6003, 1'b0);
    wait_pkts(p + 1);
    build_exp(32'd0, 64'h6000, 64'd1, 64'd4, 64'd4, 64'd4, 64'd4, 64'd0, 64'd0, 64'd0);
    compare_pkt("len_lowered", base);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/integration_window_capture.md
Name: integration_window_capture

Overview:
- Next-generation per-channel integrator for the ADC deserializer output: accumulates sum, sum-of-squares and valid-sample count per channel over a programmable window of sample_valid events.
- At each window close it snapshots into a shadow bank and streams one fixed-length packet on a 64-bit AXI-stream, while integration of the next window continues with no dead samples.
- Adds automatic windowing, flush on disable, drop accounting and packet backpressure handling.

Parameters:
- NUM_CH, 16, number of ADC channels.
- WIDTH, 18, signed sample width.
- ACC_WIDTH, 64, accumulator width (≤64; sign-extended to 64 in packet).
- LEN_WIDTH, 32, width of window_len and counters.
- ID, 8'hAB, packet identifier in header.

Ports:
- clk  in  1  system clock (250 MHz domain).
- rst  in  1  reset, synchronous, active-high.
- ena  in  1  integration enable.
- window_len  in  LEN_WIDTH  sample_valid events per window; 0 = no automatic close.
- in_timestamp  in  64  free-running timestamp.
- sample_valid  in  1  frame strobe from deserializer.
- sample_ch_data  in  NUM_CH*WIDTH  packed signed samples, ch0 in LSBs.
- sample_ch_valid  in  NUM_CH  per-channel valid qualifiers.
- m_tdata  out  64  packet word.
- m_tvalid  out  1  word valid.
- m_tlast  out  1  last word of packet.
- m_tready  in  1  downstream ready.
- dropped  out  LEN_WIDTH  total windows dropped since reset.

Behaviour:
- Reset: all accumulators, shadow bank, counters, dropped, m_tvalid, m_tlast, m_tdata = 0; serializer in IDLE.
- Stage 1 (one cycle after sample_valid): register sample data, per-channel valid, product data*data (signed, 2*WIDTH bits), and the valid strobe. Data and product must come from the same registered sample.
- Stage 2: for each channel with registered valid and ena, add sign-extended sample to sum, product to sumsq, and 1 to count. Frame counter increments on every registered strobe while ena. Timestamp is latched on the first strobe of a window.
- Accumulators wrap modulo 2^ACC_WIDTH; there is no saturation.
- Window close, either condition:
  - window_len != 0 and the strobe being accumulated brings the frame count to window_len (this sample belongs to the closing window);
  - ena falls while frame count > 0 (flush).
- ena low with frame count 0 produces no packet.
- On close, the shadow bank loads (accumulator + current contribution) in the same edge, and the live accumulators load 0. The next strobe starts a fresh window and adds no extra latency.
- Serializer states IDLE -> SEND -> IDLE:
  - The load enters SEND. m_tvalid rises in the cycle after the close edge, i.e. 2 cycles after the closing sample_valid.
  - A word advances only when m_tvalid && m_tready. m_tdata/m_tlast stay stable while stalled.
  - After the last word is accepted, return to IDLE. A close may load the shadow bank in that same acceptance cycle.
- Close while in SEND (shadow busy): that window's results are discarded, dropped increments, and pkt_counter still increments.
- Packet, 4+3*NUM_CH words:
  - w0 = {ID[7:0], 8'h00, 16'(word count), dropped[31:0] (low bits)}
  - w1 = start timestamp
  - w2 = pkt_counter (window index)
  - w3 = frames in window
  - then per ch0..chN-1: count, sum, sumsq.
  - m_tlast on the final sumsq.
- rst mid-packet: m_tvalid = 0 at the next edge; the partial packet is abandoned.
- window_len change takes effect on the next comparison. If it is lowered below the current frame count, close on the next strobe.

Test Plan:
- NUM_CH=2, window_len=4, ena=1, ch0 = 3,-2,5,-1, all valid -> one packet of 10 words: w3=4, ch0 count=4, sum=5, sumsq=39; m_tvalid 2 cycles after 4th strobe.
- Same, ch1 valid only on frames 1 and 3 with values 7,-7 -> ch1 count=2, sum=0, sumsq=98; frames=4.
- window_len=0, 3 samples (2,2,2), then ena low -> flush packet with count=3, sum=6, sumsq=12; ena low again with no samples -> no packet.
- window_len=1, strobes every 8 cycles, m_tready=0 for 40 cycles -> first packet held stable; following windows dropped, dropped increments per close; w0 of next emitted packet carries the drop count; pkt_counter gaps match.
- Back-to-back windows, m_tready=1 -> consecutive packets with pkt_counter 0,1,2; no sample lost between windows (sums of packets equal total input sum).
- rst asserted on 3rd word of a packet -> m_tvalid=0 next cycle, dropped=0, next window reports pkt_counter=0.
